uart_tx_cfg: RTL and testbench
==============================

UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 Parameter DATA_W, default 8, data bits per frame; legal range 5..9.
REQ-002 Parameter DIV_W, default 16, width of the baud divisor.
REQ-003 Clock clk; reset rst_n, asynchronous, active-low.
REQ-004 clk  in  1  system clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 trmt  in  1  transmit request; accepted only when tx_ready=1.
REQ-007 tx_data  in  DATA_W  frame payload, sent LSB first.
REQ-008 baud_div  in  DIV_W  clocks per bit minus one.
REQ-009 two_stop  in  1  1 = two stop bits, 0 = one stop bit.
REQ-010 TX  out  1  serial line; idles high.
REQ-011 tx_ready  out  1  holding register empty; trmt will be accepted.
REQ-012 busy  out  1  a frame is on the line.
REQ-013 tx_done  out  1  last requested frame has completed; no frame pending.

Function
REQ-014 The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP.
REQ-015 The transmitter SHALL contain a 1-entry holding register; trmt with tx_ready=1 captures tx_data, baud_div and two_stop and clears tx_ready on the next edge.
REQ-016 In IDLE with the holding register full, the block SHALL load the shift register and enter START on the next edge; TX SHALL go low on that edge.
REQ-017 trmt in IDLE with the holding register empty SHALL reach START on the second rising edge after the trmt edge (capture, then load); this is the 2-clock start latency.
REQ-018 Each bit SHALL last baud_div+1 clocks; a latched baud_div of 0 SHALL be treated as 1.
REQ-019 The per-bit counter SHALL reset to 0 at every bit boundary and at load.
REQ-020 The frame SHALL be sent as START (0), DATA_W data bits LSB first, optional PARITY, then 1 or 2 STOP (1) bits.
REQ-021 The DATA-state bit counter SHALL be sized ceil(log2(DATA_W+1)) and SHALL leave DATA after exactly DATA_W bits.
REQ-022 At the end of the last stop bit with the holding register full, the FSM SHALL enter START directly; this is back-to-back operation with no idle bit.
REQ-023 At the end of the last stop bit with the holding register empty, the FSM SHALL enter IDLE and set tx_done.
REQ-024 tx_done SHALL clear on trmt acceptance.
REQ-025 busy SHALL be 1 in START, DATA, PARITY and STOP.
REQ-026 tx_ready SHALL return to 1 on the load edge; one further frame can then be queued while the current frame is sent.
REQ-027 trmt while tx_ready=0 SHALL be ignored, with no effect on state or data.
REQ-028 Changes to baud_div or two_stop mid-frame SHALL NOT affect the frame in flight.

Reset
REQ-029 On rst_n low, the block SHALL immediately force the FSM to IDLE, TX=1, tx_ready=1, busy=0 and tx_done=1, and clear all counters and the holding register.
REQ-030 A reset mid-frame SHALL abort the frame, drive TX high within the same cycle and discard any queued frame.

Configuration
REQ-031 Macro UART_TX_PARITY_EN defined: the block SHALL add the inputs parity_en (1 bit) and parity_odd (1 bit), latched with the frame.
REQ-032 With UART_TX_PARITY_EN defined and parity_en=1, the PARITY state SHALL send the XOR of the data bits, inverted when parity_odd=1.
REQ-033 Macro UART_TX_PARITY_EN undefined: those ports and the PARITY state SHALL be absent, and DATA SHALL go directly to STOP.

Verification
REQ-034 DATA_W=8, baud_div=4, two_stop=0, trmt with 0xA5: TX SHALL read 0,1,0,1,0,0,1,0,1,1, 5 clocks per bit; tx_done SHALL rise 50 clocks after START.
REQ-035 As REQ-034 with two_stop=1: the stop interval SHALL be 10 clocks, and tx_done SHALL rise 55 clocks after START.
REQ-036 0x3C queued while 0xA5 is in flight: the 0x3C START SHALL directly follow the 0xA5 stop bit; tx_done SHALL stay 0 until 0x3C completes; a third trmt while tx_ready=0 SHALL be dropped.
REQ-037 With UART_TX_PARITY_EN and 0xA5: parity bit SHALL be 0 with parity_odd=0, and 1 with parity_odd=1; the frame SHALL be 11 bits.
REQ-038 rst_n pulsed low during data bit 3 with a frame queued: TX SHALL be 1 at once; after release, tx_ready=1, tx_done=1, and TX SHALL stay high with no further frame.
REQ-039 baud_div=0 with DATA_W=5: bits SHALL be 2 clocks each, giving a 14-clock frame.

Source files
------------

// File: rtl/uart_tx_cfg.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_cfg
// Purpose  : UART transmitter with a 1-entry holding register and per-frame
//            configuration. Each frame is START(0), DATA_W data bits LSB
//            first, an optional PARITY bit and 1 or 2 STOP(1) bits. Every
//            bit lasts baud_div+1 clocks; a baud_div of 0 is treated as 1.
//            A frame queued in the holding register starts directly after
//            the previous stop bit, with no idle bit between frames.
//
// Ports    : clk        in   system clock, rising edge
//            rst_n      in   asynchronous active-low reset
//            trmt       in   transmit request, accepted when tx_ready=1
//            tx_data    in   DATA_W-bit payload
//            baud_div   in   clocks per bit minus one
//            two_stop   in   1 = two stop bits, 0 = one
//            parity_en  in   (UART_TX_PARITY_EN only) append a parity bit
//            parity_odd in   (UART_TX_PARITY_EN only) odd parity
//            TX         out  serial line, idles high
//            tx_ready   out  holding register empty
//            busy       out  a frame is on the line
//            tx_done    out  last requested frame completed, none pending
//
// Config   : define UART_TX_PARITY_EN to add the parity ports and the
//            PARITY state; without it DATA goes straight to STOP.
//
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_cfg #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              trmt,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [DIV_W-1:0]  baud_div,
    input  logic              two_stop,
`ifdef UART_TX_PARITY_EN
    input  logic              parity_en,
    input  logic              parity_odd,
`endif
    output logic              TX,
    output logic              tx_ready,
    output logic              busy,
    output logic              tx_done
);

    localparam int c_BCNT_W = $clog2(DATA_W + 1);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_START  = 3'd1;
    localparam logic [2:0] c_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] c_PARITY = 3'd3;
`endif
    localparam logic [2:0] c_STOP   = 3'd4;

    localparam logic [c_BCNT_W-1:0] c_LAST_DATA = c_BCNT_W'(DATA_W - 1);
    localparam logic [c_BCNT_W-1:0] c_BCNT_ONE  = c_BCNT_W'(1);
    localparam logic [DIV_W-1:0]    c_DIV_ONE   = DIV_W'(1);

    // Holding register: captured on trmt acceptance
    logic              r_hold_full;
    logic [DATA_W-1:0] r_hold_data;
    logic [DIV_W-1:0]  r_hold_div;
    logic              r_hold_two;
`ifdef UART_TX_PARITY_EN
    logic              r_hold_par_en;
    logic              r_hold_par_odd;
    logic              r_par_en;
    logic              r_par_bit;
`endif

    // Frame in flight: configuration is frozen at load
    logic [2:0]          r_state;
    logic [DATA_W-1:0]   r_shift;
    logic [DIV_W-1:0]    r_div;
    logic                r_two_stop;
    logic [DIV_W-1:0]    r_baud_cnt;
    logic [c_BCNT_W-1:0] r_bit_cnt;
    logic                r_tx;
    logic                r_tx_done;

    logic w_accept;
    logic w_bit_end;
    logic w_last_stop;
    logic w_load;

    assign w_accept    = trmt & ~r_hold_full;
    assign w_bit_end   = (r_baud_cnt == r_div);
    // In STOP the bit counter counts stop bits already completed
    assign w_last_stop = (r_bit_cnt == {{(c_BCNT_W-1){1'b0}}, r_two_stop});
    // Load from IDLE, or directly from the end of the last stop bit
    assign w_load      = r_hold_full &
                         ((r_state == c_IDLE) |
                          ((r_state == c_STOP) & w_bit_end & w_last_stop));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_full    <= 1'b0;
            r_hold_data    <= '0;
            r_hold_div     <= '0;
            r_hold_two     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_hold_par_en  <= 1'b0;
            r_hold_par_odd <= 1'b0;
`endif
        end else if (w_accept) begin
            r_hold_full    <= 1'b1;
            r_hold_data    <= tx_data;
            r_hold_div     <= baud_div;
            r_hold_two     <= two_stop;
`ifdef UART_TX_PARITY_EN
            r_hold_par_en  <= parity_en;
            r_hold_par_odd <= parity_odd;
`endif
        end else if (w_load) begin
            r_hold_full    <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_IDLE;
            r_shift    <= '0;
            r_div      <= '0;
            r_two_stop <= 1'b0;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_tx       <= 1'b1;
            r_tx_done  <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_par_en   <= 1'b0;
            r_par_bit  <= 1'b0;
`endif
        end else begin
            if (w_load) begin
                r_state    <= c_START;
                r_tx       <= 1'b0;
                r_shift    <= r_hold_data;
                r_div      <= (r_hold_div == '0) ? c_DIV_ONE : r_hold_div;
                r_two_stop <= r_hold_two;
                r_baud_cnt <= '0;
                r_bit_cnt  <= '0;
`ifdef UART_TX_PARITY_EN
                r_par_en   <= r_hold_par_en;
                r_par_bit  <= (^r_hold_data) ^ r_hold_par_odd;
`endif
            end else if (r_state != c_IDLE) begin
                if (!w_bit_end) begin
                    r_baud_cnt <= r_baud_cnt + c_DIV_ONE;
                end else begin
                    r_baud_cnt <= '0;
                    case (r_state)
                        c_START: begin
                            r_state   <= c_DATA;
                            r_tx      <= r_shift[0];
                            r_shift   <= r_shift >> 1;
                            r_bit_cnt <= '0;
                        end
                        c_DATA: begin
                            if (r_bit_cnt == c_LAST_DATA) begin
                                r_bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                                if (r_par_en) begin
                                    r_state <= c_PARITY;
                                    r_tx    <= r_par_bit;
                                end else begin
                                    r_state <= c_STOP;
                                    r_tx    <= 1'b1;
                                end
`else
                                r_state   <= c_STOP;
                                r_tx      <= 1'b1;
`endif
                            end else begin
                                r_tx      <= r_shift[0];
                                r_shift   <= r_shift >> 1;
                                r_bit_cnt <= r_bit_cnt + c_BCNT_ONE;
                            end
                        end
`ifdef UART_TX_PARITY_EN
                        c_PARITY: begin
                            r_state   <= c_STOP;
                            r_tx      <= 1'b1;
                            r_bit_cnt <= '0;
                        end
`endif
                        c_STOP: begin
                            // Last stop with a queued frame is handled by w_load
                            if (w_last_stop) begin
                                r_state   <= c_IDLE;
                                r_tx      <= 1'b1;
                                r_tx_done <= 1'b1;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + c_BCNT_ONE;
                            end
                        end
                        default: begin
                            r_state <= c_IDLE;
                            r_tx    <= 1'b1;
                        end
                    endcase
                end
            end
            // Acceptance wins over a same-edge completion: a frame is pending
            if (w_accept) begin
                r_tx_done <= 1'b0;
            end
        end
    end

    assign TX       = r_tx;
    assign tx_ready = ~r_hold_full;
    assign busy     = (r_state != c_IDLE);
    assign tx_done  = r_tx_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_cfg.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_cfg
// Purpose  : Self-checking bench for uart_tx_cfg: directed frame table,
//            back-to-back, reset-abort and DATA_W=5 sequences, then random
//            traffic compared cycle by cycle with a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_cfg;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        trmt     = 1'b0;
    logic [7:0]  tx_data  = 8'h00;
    logic [15:0] baud_div = 16'd0;
    logic        two_stop = 1'b0;
`ifdef UART_TX_PARITY_EN
    logic        parity_en  = 1'b0;
    logic        parity_odd = 1'b0;
`endif
    logic        tx_line, tx_ready, busy, tx_done;

    logic        trmt5 = 1'b0;
    logic [4:0]  data5 = 5'd0;
    logic        tx5, rdy5, busy5, done5;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    uart_tx_cfg #(.DATA_W(8), .DIV_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .trmt(trmt), .tx_data(tx_data),
        .baud_div(baud_div), .two_stop(two_stop),
`ifdef UART_TX_PARITY_EN
        .parity_en(parity_en), .parity_odd(parity_odd),
`endif
        .TX(tx_line), .tx_ready(tx_ready), .busy(busy), .tx_done(tx_done)
    );

    uart_tx_cfg #(.DATA_W(5), .DIV_W(16)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .trmt(trmt5), .tx_data(data5),
        .baud_div(16'd0), .two_stop(1'b0),
`ifdef UART_TX_PARITY_EN
        .parity_en(1'b0), .parity_odd(1'b0),
`endif
        .TX(tx5), .tx_ready(rdy5), .busy(busy5), .tx_done(done5)
    );

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Raise trmt for one edge; returns at the negedge after the capture edge
    task automatic send(input logic [7:0] d, input logic [15:0] div, input logic two);
        trmt     = 1'b1;
        tx_data  = d;
        baud_div = div;
        two_stop = two;
        step();
        trmt = 1'b0;
    endtask

    // Called at the negedge after the load edge; returns at the negedge of
    // the frame's last cycle. bits[k] is the k-th bit on the line.
    task automatic check_frame(input string name, input logic [15:0] bits,
                               input int nb, input int b);
        for (int k = 0; k < nb; k++) begin
            int bad = 0;
            for (int j = 0; j < b; j++) begin
                if (k > 0 || j > 0) step();
                if (tx_line !== bits[k] || busy !== 1'b1 || tx_done !== 1'b0) bad++;
            end
            chk($sformatf("%s bit%0d wrong_cycles", name, k), bad, 0);
        end
    endtask

    // Cycles from the load edge until tx_done, or -1 if it never rises
    task automatic done_latency(input int spent, output int lat);
        lat = -1;
        for (int w = 0; w < 12; w++) begin
            step();
            if (tx_done === 1'b1) begin
                lat = spent + w + 1;
                break;
            end
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (!(tx_done === 1'b1 && tx_ready === 1'b1) && n < 400) begin
            step();
            n++;
        end
        chk({name, " idle"}, {30'd0, tx_done, tx_ready}, 32'd3);
    endtask

    // ---------------- frame-level reference model ----------------
    typedef struct {
        int          l;     // load edge: first edge with the start bit
        int          e;     // edge at which the line is released
        int          b;     // clocks per bit
        logic [15:0] bits;
    } frame_t;
    frame_t fq[$];

    function automatic bit m_ready(int t);
        return (fq.size() == 0) || (fq[$].l <= t);
    endfunction

    function automatic bit m_done(int t);
        return (fq.size() == 0) || (fq[$].e <= t);
    endfunction

    function automatic bit m_busy(int t);
        foreach (fq[i]) if (fq[i].l <= t && t < fq[i].e) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_tx(int t);
        foreach (fq[i]) if (fq[i].l <= t && t < fq[i].e) return fq[i].bits[(t - fq[i].l) / fq[i].b];
        return 1'b1;
    endfunction

    function automatic void m_accept(int a, logic [7:0] d, int div, bit two, bit pe, bit po);
        frame_t f;
        int n;
        f.b    = ((div == 0) ? 1 : div) + 1;
        f.bits = '1;
        f.bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) f.bits[1 + i] = d[i];
        n = 9;
        if (pe) begin
            f.bits[n] = (^d) ^ po;
            n++;
        end
        n = n + (two ? 2 : 1);
        f.l = a + 1;
        if (fq.size() != 0 && fq[$].e > f.l) f.l = fq[$].e;
        f.e = f.l + n * f.b;
        fq.push_back(f);
    endfunction

    function automatic void m_prune(int t);
        while (fq.size() > 1 && fq[0].e <= t) void'(fq.pop_front());
    endfunction

    // ---------------- directed table ----------------
    typedef struct {
        logic [7:0]  data;
        logic [15:0] div;
        logic        two;
        int          nb;
        logic [15:0] bits;
        int          b;
        int          done_lat;
    } vec_t;

    vec_t vt[5];
    int   lat;
    int   bad;
    logic [3:0]  exp4;
    logic [15:0] exp5;
    bit          r_t, r_two, r_pe, r_po;
    logic [7:0]  r_d;
    int          r_dv;

    initial begin
        vt[0] = '{8'hA5, 16'd4, 1'b0, 10, 16'b0000_0011_0100_1010, 5, 50};
        vt[1] = '{8'hA5, 16'd4, 1'b1, 11, 16'b0000_0111_0100_1010, 5, 55};
        vt[2] = '{8'h00, 16'd1, 1'b0, 10, 16'b0000_0010_0000_0000, 2, 20};
        vt[3] = '{8'hFF, 16'd0, 1'b1, 11, 16'b0000_0111_1111_1110, 2, 22};
        vt[4] = '{8'h3C, 16'd2, 1'b0, 10, 16'b0000_0010_0111_1000, 3, 30};

        repeat (3) @(negedge clk);
        chk("reset tx", {31'd0, tx_line}, 32'd1);
        rst_n = 1'b1;
        step();
        chk("reset state {tx,ready,busy,done}", {28'd0, tx_line, tx_ready, busy, tx_done}, 32'hD);

        for (int i = 0; i < 5; i++) begin
            send(vt[i].data, vt[i].div, vt[i].two);
            chk($sformatf("row%0d capture {tx,ready,done}", i), {29'd0, tx_line, tx_ready, tx_done}, 32'h4);
            step();
            chk($sformatf("row%0d ready after load", i), {31'd0, tx_ready}, 32'd1);
            check_frame($sformatf("row%0d", i), vt[i].bits, vt[i].nb, vt[i].b);
            done_latency(vt[i].nb * vt[i].b - 1, lat);
            chk($sformatf("row%0d done latency", i), lat, vt[i].done_lat);
        end

        // back-to-back, config change mid-frame, dropped third request
        send(8'hA5, 16'd4, 1'b0);
        step();
        fork
            check_frame("b2b A5", 16'b0000_0011_0100_1010, 10, 5);
            begin
                chk("b2b ready for queue", {31'd0, tx_ready}, 32'd1);
                send(8'h3C, 16'd4, 1'b0);
                baud_div = 16'd1;
                two_stop = 1'b1;
                repeat (3) step();
                chk("b2b ready while queued", {31'd0, tx_ready}, 32'd0);
                trmt    = 1'b1;
                tx_data = 8'h77;
                step();
                trmt = 1'b0;
            end
        join
        step();
        check_frame("b2b 3C", 16'b0000_0010_0111_1000, 10, 5);
        step();
        chk("b2b end {tx,ready,busy,done}", {28'd0, tx_line, tx_ready, busy, tx_done}, 32'hD);
        bad = 0;
        repeat (30) begin
            step();
            if (tx_line !== 1'b1 || busy !== 1'b0) bad++;
        end
        chk("b2b third dropped, line idle", bad, 0);

        // reset during data bit 3 with a frame queued
        send(8'hA5, 16'd4, 1'b0);
        step();
        send(8'h3C, 16'd4, 1'b0);
        repeat (21) step();
        chk("rst pre data bit3 tx", {31'd0, tx_line}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst async {tx,ready,busy,done}", {28'd0, tx_line, tx_ready, busy, tx_done}, 32'hD);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (40) begin
            step();
            if (tx_line !== 1'b1 || busy !== 1'b0) bad++;
        end
        chk("rst no frame after release", bad, 0);
        chk("rst after release {ready,done}", {30'd0, tx_ready, tx_done}, 32'd3);

        // DATA_W=5, baud_div=0: 2 clocks per bit, 14-clock frame
        exp5  = 16'b0000_0000_0110_1010;
        trmt5 = 1'b1;
        data5 = 5'h15;
        step();
        trmt5 = 1'b0;
        step();
        bad = 0;
        for (int j = 0; j < 14; j++) begin
            if (j > 0) step();
            if (tx5 !== exp5[j / 2] || busy5 !== 1'b1 || rdy5 !== 1'b1) bad++;
        end
        chk("w5 frame wrong_cycles", bad, 0);
        lat = -1;
        for (int w = 0; w < 6; w++) begin
            step();
            if (done5 === 1'b1) begin
                lat = 14 + w;
                break;
            end
        end
        chk("w5 done latency", lat, 14);

`ifdef UART_TX_PARITY_EN
        for (int p = 0; p < 2; p++) begin
            parity_en  = 1'b1;
            parity_odd = p[0];
            send(8'hA5, 16'd4, 1'b0);
            step();
            check_frame($sformatf("par odd=%0d", p),
                        (p == 0) ? 16'b0000_0101_0100_1010 : 16'b0000_0111_0100_1010, 11, 5);
            done_latency(54, lat);
            chk($sformatf("par odd=%0d done latency", p), lat, 55);
        end
        parity_en  = 1'b0;
        parity_odd = 1'b0;
`endif

        // random traffic against the frame-level model
        wait_idle("pre-random");
        cyc = 0;
        fq.delete();
        for (int n = 0; n < 3000; n++) begin
            r_t   = ($urandom_range(0, 3) == 0);
            r_d   = 8'($urandom);
            r_dv  = $urandom_range(0, 3);
            r_two = 1'($urandom);
            r_pe  = 1'b0;
            r_po  = 1'b0;
`ifdef UART_TX_PARITY_EN
            r_pe       = 1'($urandom);
            r_po       = 1'($urandom);
            parity_en  = r_pe;
            parity_odd = r_po;
`endif
            trmt     = r_t;
            tx_data  = r_d;
            baud_div = 16'(r_dv);
            two_stop = r_two;
            @(posedge clk);
            cyc++;
            if (r_t && m_ready(cyc - 1)) m_accept(cyc, r_d, r_dv, r_two, r_pe, r_po);
            @(negedge clk);
            exp4 = {m_tx(cyc), m_ready(cyc), m_busy(cyc), m_done(cyc)};
            chk($sformatf("rand cyc%0d {tx,ready,busy,done}", cyc),
                {28'd0, tx_line, tx_ready, busy, tx_done}, {28'd0, exp4});
            m_prune(cyc);
        end
        trmt = 1'b0;
        wait_idle("post-random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
